// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_RESP = 2'd1,
    S_HOLD = 2'd2,
    S_EXEC = 2'd3
  } ifu_state_t;

  localparam logic [31:0] NOP_INST             = 32'h0000_0013;
  localparam logic        FETCH_CAUSE_ACCESS   = 1'b0;
  localparam logic        FETCH_CAUSE_MISALIGN = 1'b1;

  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction-memory request/response bus plus the fetched-instruction handoff to decode.
interface ifu_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic        imem_resp_ready;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_fault;
  logic        fetch_cause;

  // master = fetch unit side
  modport master (
    output imem_req_valid, imem_req_addr, imem_resp_ready,
    output inst_valid, inst, inst_pc, fetch_fault, fetch_cause,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
    input  inst_ready
  );

  // slave = memory and decode side
  modport slave (
    input  imem_req_valid, imem_req_addr, imem_resp_ready,
    input  inst_valid, inst, inst_pc, fetch_fault, fetch_cause,
    output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
    output inst_ready
  );
endinterface

// File: rtl/ifu_fetch.sv
// Fetch unit: owns the PC, fetches one word at a time and holds it for decode
// until the backend commits the next PC.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      pc,
  input  logic [31:0]      next_pc,
  input  logic             pc_update,
  output logic [CNT_W-1:0] fetch_cnt,
  ifu_fetch_if.master      bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ifu_state_t       state_reg;
  logic [31:0]      pc_reg;
  logic             req_valid_reg;
  logic             resp_ready_reg;
  logic             inst_valid_reg;
  logic [31:0]      inst_reg;
  logic [31:0]      inst_pc_reg;
  logic             fault_reg;
  logic             cause_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_REQ;
      pc_reg         <= RESET_PC;
      req_valid_reg  <= 1'b0;
      resp_ready_reg <= 1'b0;
      inst_valid_reg <= 1'b0;
      inst_reg       <= NOP_INST;
      inst_pc_reg    <= 32'h0;
      fault_reg      <= 1'b0;
      cause_reg      <= FETCH_CAUSE_ACCESS;
      cnt_reg        <= '0;
    end else begin
      case (state_reg)
        S_REQ: begin
          // A misaligned PC never reaches the bus; it becomes a faulting NOP.
          if (!is_aligned(pc_reg)) begin
            inst_reg       <= NOP_INST;
            inst_pc_reg    <= pc_reg;
            fault_reg      <= 1'b1;
            cause_reg      <= FETCH_CAUSE_MISALIGN;
            inst_valid_reg <= 1'b1;
            state_reg      <= S_HOLD;
          end else if (!req_valid_reg) begin
            req_valid_reg <= 1'b1;
          end else if (bus.imem_req_ready) begin
            req_valid_reg  <= 1'b0;
            resp_ready_reg <= 1'b1;
            state_reg      <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.imem_resp_valid) begin
            resp_ready_reg <= 1'b0;
            inst_reg       <= bus.imem_resp_err ? NOP_INST : bus.imem_resp_data;
            inst_pc_reg    <= pc_reg;
            fault_reg      <= bus.imem_resp_err;
            cause_reg      <= FETCH_CAUSE_ACCESS;
            inst_valid_reg <= 1'b1;
            state_reg      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.inst_ready) begin
            inst_valid_reg <= 1'b0;
            cnt_reg        <= cnt_reg + CNT_ONE;
            if (pc_update) begin
              pc_reg        <= next_pc;
              req_valid_reg <= is_aligned(next_pc);
              state_reg     <= S_REQ;
            end else begin
              state_reg <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (pc_update) begin
            pc_reg        <= next_pc;
            req_valid_reg <= is_aligned(next_pc);
            state_reg     <= S_REQ;
          end
        end
        default: state_reg <= S_REQ;
      endcase
    end
  end

  assign pc                  = pc_reg;
  assign fetch_cnt           = cnt_reg;
  assign bus.imem_req_valid  = req_valid_reg;
  assign bus.imem_req_addr   = pc_reg;
  assign bus.imem_resp_ready = resp_ready_reg;
  assign bus.inst_valid      = inst_valid_reg;
  assign bus.inst            = inst_reg;
  assign bus.inst_pc         = inst_pc_reg;
  assign bus.fetch_fault     = fault_reg;
  assign bus.fetch_cause     = cause_reg;

endmodule
